// File: rtl/usb_rx_pkt.sv
// usb_rx_pkt: turns the ULPI receive byte stream into token, handshake and
// DATAx reports. The DATAx payload is forwarded with the PID and CRC16 removed.
module usb_rx_pkt #(
  parameter logic SOF_REPORT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       rx_error,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tlast,
  output logic       m_axis_tvalid,
  output logic [3:0] pkt_pid,
  output logic       token_valid,
  output logic [6:0] token_addr,
  output logic [3:0] token_endp,
  output logic       hs_valid,
  output logic       data_done,
  output logic       data_crc_ok,
  output logic       pkt_error
);

  localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
  localparam logic [3:0]  PID_SOF        = 4'b0101;

  typedef enum logic [1:0] {IDLE, TOKEN, DATA, DROP} state_t;

  state_t      state_q;
  logic        tokSecond_q;
  logic [7:0]  tokByte1_q;
  logic [7:0]  hold0_q;
  logic [7:0]  hold1_q;
  logic [1:0]  holdCount_q;
  logic [4:0]  crc5_q;
  logic [4:0]  crc5_d;
  logic [15:0] crc16_q;
  logic [15:0] crc16_d;
  logic        pidValid;

  logic        tready_q;
  logic [7:0]  mTdata_q;
  logic        mTlast_q;
  logic        mTvalid_q;
  logic [3:0]  pktPid_q;
  logic        tokenValid_q;
  logic [6:0]  tokenAddr_q;
  logic [3:0]  tokenEndp_q;
  logic        hsValid_q;
  logic        dataDone_q;
  logic        dataCrcOk_q;
  logic        pktError_q;

  // Serial CRC5, data bits shifted in LSB first.
  function automatic logic [4:0] crc5Byte(input logic [4:0] crc, input logic [7:0] data);
    logic [4:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[4] ^ data[i]) c = {c[3:0], 1'b0} ^ 5'b00101;
      else                c = {c[3:0], 1'b0};
    end
    return c;
  endfunction

  // Serial CRC16, data bits shifted in LSB first.
  function automatic logic [15:0] crc16Byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // CRC values as they would stand after absorbing the byte on the bus.
  always_comb begin
    crc5_d   = crc5Byte(crc5_q, s_axis_tdata);
    crc16_d  = crc16Byte(crc16_q, s_axis_tdata);
    pidValid = (s_axis_tdata[7:4] == ~s_axis_tdata[3:0]);
  end

  // Packet parser FSM; every output is a register so reports land one cycle after the byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tokSecond_q  <= 1'b0;
      tokByte1_q   <= 8'h00;
      hold0_q      <= 8'h00;
      hold1_q      <= 8'h00;
      holdCount_q  <= 2'd0;
      crc5_q       <= 5'h00;
      crc16_q      <= 16'h0000;
      tready_q     <= 1'b0;
      mTdata_q     <= 8'h00;
      mTlast_q     <= 1'b0;
      mTvalid_q    <= 1'b0;
      pktPid_q     <= 4'h0;
      tokenValid_q <= 1'b0;
      tokenAddr_q  <= 7'h00;
      tokenEndp_q  <= 4'h0;
      hsValid_q    <= 1'b0;
      dataDone_q   <= 1'b0;
      dataCrcOk_q  <= 1'b0;
      pktError_q   <= 1'b0;
    end else begin
      tready_q     <= 1'b1;
      mTvalid_q    <= 1'b0;
      mTlast_q     <= 1'b0;
      tokenValid_q <= 1'b0;
      hsValid_q    <= 1'b0;
      dataDone_q   <= 1'b0;
      dataCrcOk_q  <= 1'b0;
      pktError_q   <= 1'b0;

      case (state_q)
        IDLE: begin
          if (s_axis_tvalid) begin
            if (!pidValid) begin
              pktError_q <= 1'b1;
              state_q    <= s_axis_tlast ? IDLE : DROP;
            end else begin
              pktPid_q <= s_axis_tdata[3:0];
              case (s_axis_tdata[1:0])
                2'b01: begin
                  if (s_axis_tlast) begin
                    pktError_q <= 1'b1;
                  end else begin
                    state_q     <= TOKEN;
                    tokSecond_q <= 1'b0;
                    crc5_q      <= 5'h1F;
                  end
                end
                2'b11: begin
                  if (s_axis_tlast) begin
                    pktError_q <= 1'b1;
                  end else begin
                    state_q     <= DATA;
                    holdCount_q <= 2'd0;
                    crc16_q     <= 16'hFFFF;
                  end
                end
                2'b10: begin
                  if (s_axis_tlast) begin
                    hsValid_q <= 1'b1;
                  end else begin
                    pktError_q <= 1'b1;
                    state_q    <= DROP;
                  end
                end
                default: begin
                  pktError_q <= 1'b1;
                  state_q    <= s_axis_tlast ? IDLE : DROP;
                end
              endcase
            end
          end
        end

        TOKEN: begin
          if (rx_error) begin
            pktError_q <= 1'b1;
            state_q    <= (s_axis_tvalid && s_axis_tlast) ? IDLE : DROP;
          end else if (s_axis_tvalid) begin
            crc5_q <= crc5_d;
            if (!tokSecond_q) begin
              tokByte1_q  <= s_axis_tdata;
              tokSecond_q <= 1'b1;
              if (s_axis_tlast) begin
                pktError_q <= 1'b1;
                state_q    <= IDLE;
              end
            end else if (!s_axis_tlast) begin
              pktError_q <= 1'b1;
              state_q    <= DROP;
            end else begin
              state_q <= IDLE;
              if (crc5_d != CRC5_RESIDUAL) begin
                pktError_q <= 1'b1;
              end else if (!((pktPid_q == PID_SOF) && (SOF_REPORT == 1'b0))) begin
                tokenValid_q <= 1'b1;
                tokenAddr_q  <= tokByte1_q[6:0];
                tokenEndp_q  <= {s_axis_tdata[2:0], tokByte1_q[7]};
              end
            end
          end
        end

        DATA: begin
          if (rx_error) begin
            pktError_q  <= 1'b1;
            holdCount_q <= 2'd0;
            state_q     <= (s_axis_tvalid && s_axis_tlast) ? IDLE : DROP;
          end else if (s_axis_tvalid) begin
            crc16_q <= crc16_d;
            if (holdCount_q == 2'd2) begin
              mTdata_q  <= hold0_q;
              mTvalid_q <= 1'b1;
              mTlast_q  <= s_axis_tlast;
              hold0_q   <= hold1_q;
              hold1_q   <= s_axis_tdata;
            end else if (holdCount_q == 2'd1) begin
              hold1_q     <= s_axis_tdata;
              holdCount_q <= 2'd2;
            end else begin
              hold0_q     <= s_axis_tdata;
              holdCount_q <= 2'd1;
            end
            if (s_axis_tlast) begin
              state_q <= IDLE;
              if (holdCount_q == 2'd0) begin
                pktError_q <= 1'b1;
              end else begin
                dataDone_q  <= 1'b1;
                dataCrcOk_q <= (crc16_d == CRC16_RESIDUAL);
              end
            end
          end
        end

        DROP: begin
          if (s_axis_tvalid && s_axis_tlast) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_axis_tready = tready_q;
  assign m_axis_tdata  = mTdata_q;
  assign m_axis_tlast  = mTlast_q;
  assign m_axis_tvalid = mTvalid_q;
  assign pkt_pid       = pktPid_q;
  assign token_valid   = tokenValid_q;
  assign token_addr    = tokenAddr_q;
  assign token_endp    = tokenEndp_q;
  assign hs_valid      = hsValid_q;
  assign data_done     = dataDone_q;
  assign data_crc_ok   = dataCrcOk_q;
  assign pkt_error     = pktError_q;

endmodule

// File: tb/tb_usb_rx_pkt.sv
// tb_usb_rx_pkt: scoreboard bench for usb_rx_pkt. Each test queues the beats and
// report pulses it expects, drives bytes, and a negedge monitor pops and compares.
module tb_usb_rx_pkt;

  typedef struct {
    int         kind;   // 0 token, 1 handshake, 2 data done, 3 packet error
    logic [3:0] pid;
    logic [6:0] addr;
    logic [3:0] endp;
    logic       crcOk;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tlast;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic       rx_error;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tlast;
  logic       m_axis_tvalid;
  logic [3:0] pkt_pid;
  logic       token_valid;
  logic [6:0] token_addr;
  logic [3:0] token_endp;
  logic       hs_valid;
  logic       data_done;
  logic       data_crc_ok;
  logic       pkt_error;

  int assertCount = 0;
  int failCount   = 0;

  logic [8:0] txQ[$];
  logic [8:0] expBeats[$];
  ev_t        expEv[$];

  always #5 clk = ~clk;

  usb_rx_pkt #(.SOF_REPORT(1'b1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .rx_error      (rx_error),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .pkt_pid       (pkt_pid),
    .token_valid   (token_valid),
    .token_addr    (token_addr),
    .token_endp    (token_endp),
    .hs_valid      (hs_valid),
    .data_done     (data_done),
    .data_crc_ok   (data_crc_ok),
    .pkt_error     (pkt_error)
  );

  // Monitor: every payload beat and report pulse must match the head of its queue.
  always @(negedge clk) begin : monitor
    int         nPulse;
    int         kind;
    ev_t        e;
    logic [8:0] b;
    if (rst_n) begin
      if (m_axis_tvalid) begin
        assertCount++;
        if (expBeats.size() == 0) begin
          failCount++;
          $display("[TB] FAIL beat_unexpected: got tlast=%0b tdata=%h, required no beat", m_axis_tlast, m_axis_tdata);
        end else begin
          b = expBeats.pop_front();
          if ({m_axis_tlast, m_axis_tdata} !== b) begin
            failCount++;
            $display("[TB] FAIL beat_value: got tlast=%0b tdata=%h, required tlast=%0b tdata=%h",
                     m_axis_tlast, m_axis_tdata, b[8], b[7:0]);
          end
        end
      end
      nPulse = int'(token_valid) + int'(hs_valid) + int'(data_done) + int'(pkt_error);
      if (nPulse > 0) begin
        assertCount++;
        if (nPulse > 1) begin
          failCount++;
          $display("[TB] FAIL pulse_exclusive: got %0d report pulses together, required 1", nPulse);
        end
        kind = token_valid ? 0 : hs_valid ? 1 : data_done ? 2 : 3;
        assertCount++;
        if (expEv.size() == 0) begin
          failCount++;
          $display("[TB] FAIL report_unexpected: got report kind %0d, required none", kind);
        end else begin
          e = expEv.pop_front();
          if (kind !== e.kind) begin
            failCount++;
            $display("[TB] FAIL report_kind: got kind %0d, required kind %0d", kind, e.kind);
          end else if (kind == 0 && {pkt_pid, token_addr, token_endp} !== {e.pid, e.addr, e.endp}) begin
            failCount++;
            $display("[TB] FAIL token_fields: got pid=%h addr=%h endp=%h, required pid=%h addr=%h endp=%h",
                     pkt_pid, token_addr, token_endp, e.pid, e.addr, e.endp);
          end else if (kind == 1 && pkt_pid !== e.pid) begin
            failCount++;
            $display("[TB] FAIL hs_pid: got pid=%h, required pid=%h", pkt_pid, e.pid);
          end else if (kind == 2 && {pkt_pid, data_crc_ok} !== {e.pid, e.crcOk}) begin
            failCount++;
            $display("[TB] FAIL data_done_fields: got pid=%h crc_ok=%0b, required pid=%h crc_ok=%0b",
                     pkt_pid, data_crc_ok, e.pid, e.crcOk);
          end
        end
      end
    end
  end

  // Hard time limit so a broken DUT cannot hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pushEv(input int kind, input logic [3:0] pid, input logic [6:0] addr,
                        input logic [3:0] endp, input logic ok);
    ev_t e;
    e.kind = kind; e.pid = pid; e.addr = addr; e.endp = endp; e.crcOk = ok;
    expEv.push_back(e);
  endtask

  task automatic addRaw(input logic [7:0] b, input logic last);
    txQ.push_back({last, b});
  endtask

  // Token with CRC5 computed in the reflected (shift-right) form.
  task automatic buildToken(input logic [3:0] pid, input logic [6:0] addr,
                            input logic [3:0] endp, input logic report);
    logic [10:0] v;
    logic [4:0]  c;
    v = {endp, addr};
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      if (c[0] ^ v[i]) c = (c >> 1) ^ 5'h14;
      else             c = c >> 1;
    end
    c = ~c;
    addRaw({~pid, pid}, 1'b0);
    addRaw({endp[0], addr}, 1'b0);
    addRaw({c, endp[3:1]}, 1'b1);
    if (report) pushEv(0, pid, addr, endp, 1'b0);
  endtask

  // Random DATAx packet with a valid CRC16 computed in the reflected form.
  task automatic buildData(input logic [3:0] pid, input int len);
    logic [15:0] c;
    logic [7:0]  b;
    logic        last;
    c = 16'hFFFF;
    addRaw({~pid, pid}, 1'b0);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      last = (i == len - 1);
      addRaw(b, 1'b0);
      expBeats.push_back({last, b});
      c = c ^ {8'h00, b};
      for (int j = 0; j < 8; j++) begin
        if (c[0]) c = (c >> 1) ^ 16'hA001;
        else      c = c >> 1;
      end
    end
    c = ~c;
    addRaw(c[7:0], 1'b0);
    addRaw(c[15:8], 1'b1);
    pushEv(2, pid, 7'h00, 4'h0, 1'b1);
  endtask

  // Drive txQ, optionally with idle gaps and an rx_error cycle before byte errAt.
  task automatic applyStimulus(input int gapMax, input int errAt);
    for (int i = 0; i < txQ.size(); i++) begin
      if (i == errAt) begin
        @(negedge clk);
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; rx_error = 1'b1;
      end
      if (gapMax > 0) begin
        repeat ($urandom_range(gapMax, 0)) begin
          @(negedge clk);
          s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; rx_error = 1'b0;
        end
      end
      @(negedge clk);
      rx_error      = 1'b0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = txQ[i][7:0];
      s_axis_tlast  = txQ[i][8];
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = 8'h00; rx_error = 1'b0;
    @(posedge clk);
    #1;
    txQ.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = 8'h00; rx_error = 1'b0;
    repeat (3) @(negedge clk);
    assertCount++;
    if ({s_axis_tready, m_axis_tdata, m_axis_tlast, m_axis_tvalid, pkt_pid, token_valid, token_addr,
         token_endp, hs_valid, data_done, data_crc_ok, pkt_error} !== 31'h0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: got tready=%0b pid=%h addr=%h endp=%h, required all zero",
               s_axis_tready, pkt_pid, token_addr, token_endp);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    assertCount++;
    if (s_axis_tready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL tready_after_reset: got %0b, required 1", s_axis_tready);
    end
  endtask

  task automatic test_token();
    addRaw(8'h2D, 1'b0); addRaw(8'h00, 1'b0); addRaw(8'h10, 1'b1);
    pushEv(0, 4'hD, 7'h00, 4'h0, 1'b0);
    buildToken(4'b1001, 7'h3A, 4'hA, 1'b1);
    buildToken(4'b0101, 7'h23, 4'hB, 1'b1);
    applyStimulus(0, -1);
    assertCount++;
    if (expEv.size() != 0 || expBeats.size() != 0) begin
      failCount++;
      $display("[TB] FAIL token_drain: pending events=%0d beats=%0d, required 0", expEv.size(), expBeats.size());
    end
  endtask

  task automatic test_token_errors();
    buildToken(4'b0001, 7'h55, 4'h3, 1'b0);
    txQ[2] = txQ[2] ^ 9'h080;
    pushEv(3, 4'h0, 7'h00, 4'h0, 1'b0);
    addRaw(8'h69, 1'b0); addRaw(8'h05, 1'b1);
    pushEv(3, 4'h0, 7'h00, 4'h0, 1'b0);
    addRaw(8'hB4, 1'b0); addRaw(8'h01, 1'b0); addRaw(8'h02, 1'b1);
    pushEv(3, 4'h0, 7'h00, 4'h0, 1'b0);
    applyStimulus(1, -1);
    assertCount++;
    if (expEv.size() != 0 || expBeats.size() != 0) begin
      failCount++;
      $display("[TB] FAIL token_err_drain: pending events=%0d beats=%0d, required 0", expEv.size(), expBeats.size());
    end
  endtask

  task automatic test_data();
    logic [7:0] payload[8];
    payload = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
    for (int pass = 0; pass < 2; pass++) begin
      addRaw(8'hC3, 1'b0);
      for (int i = 0; i < 8; i++) begin
        logic [7:0] b;
        logic       last;
        b = (pass == 1 && i == 6) ? 8'h41 : payload[i];
        last = (i == 7);
        addRaw(b, 1'b0);
        expBeats.push_back({last, b});
      end
      addRaw(8'hDD, 1'b0); addRaw(8'h94, 1'b1);
      pushEv(2, 4'h3, 7'h00, 4'h0, (pass == 0));
      applyStimulus(0, -1);
      assertCount++;
      if (expEv.size() != 0 || expBeats.size() != 0) begin
        failCount++;
        $display("[TB] FAIL data_drain_%0d: pending events=%0d beats=%0d, required 0", pass, expEv.size(), expBeats.size());
      end
    end
  endtask

  task automatic test_handshake_zlp();
    addRaw(8'hD2, 1'b1);
    pushEv(1, 4'h2, 7'h00, 4'h0, 1'b0);
    addRaw(8'h4B, 1'b0); addRaw(8'h00, 1'b0); addRaw(8'h00, 1'b1);
    pushEv(2, 4'hB, 7'h00, 4'h0, 1'b1);
    addRaw(8'h5A, 1'b0); addRaw(8'h00, 1'b1);
    pushEv(3, 4'h0, 7'h00, 4'h0, 1'b0);
    addRaw(8'hC3, 1'b0); addRaw(8'h00, 1'b1);
    pushEv(3, 4'h0, 7'h00, 4'h0, 1'b0);
    applyStimulus(0, -1);
    assertCount++;
    if (expEv.size() != 0 || expBeats.size() != 0) begin
      failCount++;
      $display("[TB] FAIL hs_zlp_drain: pending events=%0d beats=%0d, required 0", expEv.size(), expBeats.size());
    end
    assertCount++;
    if (pkt_pid !== 4'h3) begin
      failCount++;
      $display("[TB] FAIL short_data_pid: got %h, required 3", pkt_pid);
    end
  endtask

  task automatic test_bad_pid();
    addRaw(8'h2E, 1'b0); addRaw(8'h00, 1'b0); addRaw(8'h10, 1'b1);
    pushEv(3, 4'h0, 7'h00, 4'h0, 1'b0);
    addRaw(8'hD2, 1'b1);
    pushEv(1, 4'h2, 7'h00, 4'h0, 1'b0);
    applyStimulus(0, -1);
    assertCount++;
    if (expEv.size() != 0 || expBeats.size() != 0) begin
      failCount++;
      $display("[TB] FAIL bad_pid_drain: pending events=%0d beats=%0d, required 0", expEv.size(), expBeats.size());
    end
  endtask

  task automatic test_rx_error();
    addRaw(8'hC3, 1'b0); addRaw(8'h80, 1'b0); addRaw(8'h06, 1'b0); addRaw(8'h00, 1'b0);
    addRaw(8'h01, 1'b0); addRaw(8'h00, 1'b0); addRaw(8'h00, 1'b0); addRaw(8'h40, 1'b0);
    addRaw(8'h00, 1'b0); addRaw(8'hDD, 1'b0); addRaw(8'h94, 1'b1);
    expBeats.push_back({1'b0, 8'h80});
    expBeats.push_back({1'b0, 8'h06});
    pushEv(3, 4'h0, 7'h00, 4'h0, 1'b0);
    addRaw(8'hD2, 1'b1);
    pushEv(1, 4'h2, 7'h00, 4'h0, 1'b0);
    applyStimulus(0, 5);
    assertCount++;
    if (expEv.size() != 0 || expBeats.size() != 0) begin
      failCount++;
      $display("[TB] FAIL rx_error_drain: pending events=%0d beats=%0d, required 0", expEv.size(), expBeats.size());
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'hC3; s_axis_tlast = 1'b0;
    @(negedge clk);
    s_axis_tdata = 8'h80;
    @(negedge clk);
    s_axis_tvalid = 1'b0; s_axis_tdata = 8'h00;
    assertCount++;
    if (pkt_pid !== 4'h3) begin
      failCount++;
      $display("[TB] FAIL mid_pid_before_reset: got %h, required 3", pkt_pid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    assertCount++;
    if ({s_axis_tready, m_axis_tdata, m_axis_tlast, m_axis_tvalid, pkt_pid, token_valid, token_addr,
         token_endp, hs_valid, data_done, data_crc_ok, pkt_error} !== 31'h0) begin
      failCount++;
      $display("[TB] FAIL mid_reset_outputs: got tready=%0b pid=%h err=%0b, required all zero",
               s_axis_tready, pkt_pid, pkt_error);
    end
    rst_n = 1'b1;
    addRaw(8'hD2, 1'b1);
    pushEv(1, 4'h2, 7'h00, 4'h0, 1'b0);
    applyStimulus(0, -1);
    assertCount++;
    if (expEv.size() != 0 || expBeats.size() != 0) begin
      failCount++;
      $display("[TB] FAIL mid_reset_drain: pending events=%0d beats=%0d, required 0", expEv.size(), expBeats.size());
    end
  endtask

  task automatic test_random_data();
    logic [3:0] pids[4];
    pids = '{4'b0011, 4'b1011, 4'b0111, 4'b1111};
    for (int k = 0; k < 6; k++) begin
      buildData(pids[k % 4], $urandom_range(12, 1));
      applyStimulus(2, -1);
      assertCount++;
      if (expEv.size() != 0 || expBeats.size() != 0) begin
        failCount++;
        $display("[TB] FAIL random_data_drain_%0d: pending events=%0d beats=%0d, required 0", k, expEv.size(), expBeats.size());
      end
    end
  endtask

  task automatic test_back_to_back();
    buildToken(4'b1001, 7'h05, 4'h1, 1'b1);
    buildData(4'b0011, 3);
    addRaw(8'hD2, 1'b1);
    pushEv(1, 4'h2, 7'h00, 4'h0, 1'b0);
    buildToken(4'b0001, 7'h7F, 4'hF, 1'b1);
    applyStimulus(0, -1);
    assertCount++;
    if (expEv.size() != 0 || expBeats.size() != 0) begin
      failCount++;
      $display("[TB] FAIL back_to_back_drain: pending events=%0d beats=%0d, required 0", expEv.size(), expBeats.size());
    end
  endtask

  initial begin
    test_reset();
    test_token();
    test_token_errors();
    test_data();
    test_handshake_zlp();
    test_bad_pid();
    test_rx_error();
    test_reset_mid();
    test_random_data();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/usb_rx_pkt.md
USB_RX_PKT -- requirements
Module: usb_rx_pkt

Interface
REQ-001 The block SHALL have parameter SOF_REPORT, default 1, meaning 1 = SOF tokens raise token_valid and 0 = SOF tokens are checked but not reported.
REQ-002 The block SHALL have port clk, input, 1 bit: the ULPI-domain clock; all logic is in this single clock domain.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have ports s_axis_tdata (input, 8), s_axis_tlast (input, 1) and s_axis_tvalid (input, 1): the received-packet byte stream from the ULPI controller, one packet per tlast.
REQ-005 The block SHALL have port s_axis_tready, output, 1 bit: always 1 outside reset (RX cannot be stalled).
REQ-006 The block SHALL have port rx_error, input, 1 bit: PHY RxError, sampled on any cycle.
REQ-007 The block SHALL have ports m_axis_tdata (output, 8), m_axis_tlast (output, 1) and m_axis_tvalid (output, 1): DATAx payload with PID and CRC16 stripped; there is no tready.
REQ-008 The block SHALL have port pkt_pid, output, 4 bits: PID[3:0] of the last accepted packet.
REQ-009 The block SHALL have ports token_valid (output, 1), token_addr (output, 7) and token_endp (output, 4): a one-cycle token report; for SOF, {token_endp, token_addr} = frame number.
REQ-010 The block SHALL have port hs_valid, output, 1 bit: one-cycle pulse for a valid ACK/NAK/STALL/NYET.
REQ-011 The block SHALL have ports data_done (output, 1) and data_crc_ok (output, 1): a one-cycle end-of-DATAx pulse with its CRC16 result.
REQ-012 The block SHALL have port pkt_error, output, 1 bit: one-cycle pulse for any rejected packet.

Function
REQ-013 The block SHALL implement the states IDLE, TOKEN, DATA and DROP; a byte is consumed only when s_axis_tvalid=1.
REQ-014 In IDLE, the first byte is the PID; if tdata[7:4] != ~tdata[3:0], the block SHALL pulse pkt_error and go to DROP, or stay in IDLE if tlast=1 on that byte.
REQ-015 For a valid PID, the block SHALL latch pkt_pid; types: token 01 (OUT, IN, SOF, SETUP), data 11 (DATA0/1/2/MDATA), handshake 10, special 00.
REQ-016 Handshake PID with tlast=1: the block SHALL pulse hs_valid the next cycle; handshake without tlast -> pkt_error, DROP.
REQ-017 Token PID: the block SHALL go to TOKEN and collect exactly 2 further bytes; the 16 bits {byte2, byte1} are checked LSB-first through CRC5 (x^5+x^2+1, init 5'b11111), and a residual of 5'b01100 is required.
REQ-018 On the 2nd token byte with tlast=1 and CRC OK, the block SHALL, one cycle later, set token_addr = byte1[6:0], token_endp = {byte2[2:0], byte1[7]} and pulse token_valid, suppressed for SOF when SOF_REPORT=0.
REQ-019 In TOKEN, tlast before byte 2, no tlast on byte 2, or a CRC5 mismatch SHALL pulse pkt_error; a missing tlast goes to DROP, otherwise the block goes to IDLE.
REQ-020 Data PID: the block SHALL go to DATA; each byte feeds CRC16 (x^16+x^15+x^2+1, init 16'hFFFF, LSB-first) and a 2-byte holding register.
REQ-021 Once two bytes are held, each new byte SHALL emit the oldest held byte on m_axis the next cycle (tvalid=1 for 1 cycle); the held bytes at tlast are the CRC and SHALL never be emitted.
REQ-022 The payload byte emitted on the tlast cycle SHALL carry m_axis_tlast=1.
REQ-023 On tlast in DATA, the block SHALL pulse data_done one cycle later with data_crc_ok = (residual == 16'h800D), aligned with the final m_axis beat.
REQ-024 A DATA packet of fewer than 2 bytes after the PID SHALL pulse pkt_error and not data_done; exactly 2 bytes (ZLP) SHALL pulse data_done with no m_axis beats.
REQ-025 Special PIDs (PRE/ERR/SPLIT/PING/reserved) SHALL pulse pkt_error, then go to DROP, or to IDLE if tlast=1.
REQ-026 rx_error=1 in TOKEN or DATA SHALL pulse pkt_error and go to DROP; the block SHALL issue no token_valid, data_done, or further m_axis beats for that packet.
REQ-027 In DROP, the block SHALL discard bytes until a byte with tlast=1, then return to IDLE.
REQ-028 At most one of token_valid, hs_valid, data_done and pkt_error SHALL be asserted in any cycle.
REQ-029 The latency from the last input byte to its report pulse SHALL be exactly 1 cycle.

Reset
REQ-030 When rst_n=0 at a clk edge, the block SHALL enter IDLE, clear the holding register and the CRC state, and drive all outputs to 0, including s_axis_tready, pkt_pid, token_addr and token_endp.
REQ-031 A reset asserted mid-packet SHALL abort the packet silently, with no pkt_error; after release, the next byte is parsed as a PID.

Verification
REQ-032 The bench SHALL cover: SETUP bytes 2D 00 10 (tlast on 10) -> token_valid, pkt_pid=D, addr=0, endp=0, no pkt_error.
REQ-033 The bench SHALL cover: C3 80 06 00 01 00 00 40 00 DD 94 -> 8 m_axis beats 80..00, tlast on the 8th, data_done with data_crc_ok=1.
REQ-034 The bench SHALL cover: the same stream with 40 replaced by 41 -> 8 beats emitted, data_done with data_crc_ok=0.
REQ-035 The bench SHALL cover: D2 (tlast) -> hs_valid, pkt_pid=2; and 4B 00 00 -> data_done, crc_ok=1, zero beats.
REQ-036 The bench SHALL cover: bad PID 2E 00 10 -> pkt_error once, next packet D2 is accepted; rx_error during C3 80 06 -> pkt_error, beats stop, no data_done.
REQ-037 The bench SHALL cover: rst_n=0 for 1 cycle after C3 80 -> all outputs 0, no pkt_error; next D2 is accepted.
